// File: rtl/spi_adc_responder_pkg.sv
// Shared constants and state type for the ADC128S022 SPI responder model.
package spi_adc_responder_pkg;

    localparam int FRAME_BITS      = 16;
    localparam int LEAD_ZEROS      = 4;
    localparam int ADDR_FIRST_RISE = 3;
    localparam int ADDR_LAST_RISE  = 5;
    localparam int NUM_CH          = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_TAIL   = 2'd2
    } resp_state_t;

endpackage

// File: rtl/spi_adc_responder_pin_sync.sv
// Multi-stage pin synchronizer with rise/fall strobes taken from the last stage.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic                   prev_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_reg <= {SYNC_STAGES{RESET_VAL}};
            prev_reg  <= RESET_VAL;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], pin};
            prev_reg  <= stage_reg[SYNC_STAGES-1];
        end
    end

    assign level = stage_reg[SYNC_STAGES-1];
    assign rise  = stage_reg[SYNC_STAGES-1] & ~prev_reg;
    assign fall  = ~stage_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_adc_responder.sv
// ADC128S022 responder: replies with chan_data of the address sent in the previous frame.
// Optional short-frame checker built when SPI_ADC_RESP_PROTO_CHECK_EN is defined.
module spi_adc_responder
    import spi_adc_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        spi_sck,
    input  logic                        spi_cs_n,
    input  logic                        spi_mosi,
    output logic                        spi_miso,
    input  logic [NUM_CH*DATA_BITS-1:0] chan_data,
    output logic                        frame_done,
    output logic [2:0]                  last_addr,
    output logic [4:0]                  frame_bits,
    output logic                        proto_err
);

    // Pin order: 0 = sck (idles low), 1 = cs_n (idles high), 2 = mosi.
    localparam logic [2:0] PIN_RST = 3'b010;

    logic [2:0] pin_vec;
    logic [2:0] level_vec;
    logic [2:0] rise_vec;
    logic [2:0] fall_vec;

    assign pin_vec = {spi_mosi, spi_cs_n, spi_sck};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        spi_pin_sync #(
            .SYNC_STAGES(SYNC_STAGES),
            .RESET_VAL  (PIN_RST[gi])
        ) u_sync (
            .clk  (clk),
            .rst  (rst),
            .pin  (pin_vec[gi]),
            .level(level_vec[gi]),
            .rise (rise_vec[gi]),
            .fall (fall_vec[gi])
        );
    end

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_level;
    assign sck_rise   = rise_vec[0];
    assign sck_fall   = fall_vec[0];
    assign cs_rise    = rise_vec[1];
    assign cs_fall    = fall_vec[1];
    assign mosi_level = level_vec[2];

    logic unused_pin_bits;
    assign unused_pin_bits = ^{rise_vec[2], fall_vec[2], level_vec[1:0]};

    resp_state_t           state_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] snapshot;
    logic [4:0]            cnt_reg;
    logic [4:0]            cnt_next;
    logic [2:0]            frame_addr_reg;
    logic [2:0]            pending_addr_reg;
    logic [2:0]            last_addr_reg;
    logic [4:0]            frame_bits_reg;
    logic                  frame_done_reg;
    logic                  miso_reg;

    assign snapshot = FRAME_BITS'(chan_data[pending_addr_reg*DATA_BITS +: DATA_BITS]);
    assign cnt_next = (cnt_reg == 5'd31) ? cnt_reg : cnt_reg + 5'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            shift_reg        <= '0;
            cnt_reg          <= '0;
            frame_addr_reg   <= '0;
            pending_addr_reg <= '0;
            last_addr_reg    <= '0;
            frame_bits_reg   <= '0;
            frame_done_reg   <= 1'b0;
            miso_reg         <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    miso_reg <= 1'b0;
                    if (cs_fall) begin
                        shift_reg      <= snapshot;
                        miso_reg       <= snapshot[FRAME_BITS-1];
                        cnt_reg        <= '0;
                        frame_addr_reg <= '0;
                        state_reg      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE, ST_TAIL: begin
                    // A cs_n edge swallows any sck edge arriving in the same clock.
                    if (cs_rise) begin
                        frame_done_reg <= 1'b1;
                        frame_bits_reg <= cnt_reg;
                        miso_reg       <= 1'b0;
                        state_reg      <= ST_IDLE;
                        if (cnt_reg >= 5'(ADDR_LAST_RISE)) begin
                            pending_addr_reg <= frame_addr_reg;
                            last_addr_reg    <= frame_addr_reg;
                        end
                    end else if (sck_rise) begin
                        cnt_reg <= cnt_next;
                        if (cnt_next == 5'(ADDR_FIRST_RISE))
                            frame_addr_reg[2] <= mosi_level;
                        if (cnt_next == 5'(ADDR_FIRST_RISE + 1))
                            frame_addr_reg[1] <= mosi_level;
                        if (cnt_next == 5'(ADDR_LAST_RISE))
                            frame_addr_reg[0] <= mosi_level;
                        if (state_reg == ST_ACTIVE && cnt_next == 5'(FRAME_BITS))
                            state_reg <= ST_TAIL;
                    end else if (sck_fall) begin
                        if (state_reg == ST_ACTIVE) begin
                            shift_reg <= shift_reg << 1;
                            miso_reg  <= shift_reg[FRAME_BITS-2];
                        end else begin
                            miso_reg <= 1'b0;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_ADC_RESP_PROTO_CHECK_EN
    logic proto_err_reg;
    always_ff @(posedge clk) begin
        if (!rst)
            proto_err_reg <= 1'b0;
        else if (cs_rise && state_reg != ST_IDLE && cnt_reg < 5'(FRAME_BITS))
            proto_err_reg <= 1'b1;
    end
    assign proto_err = proto_err_reg;
`else
    assign proto_err = 1'b0;
`endif

    assign spi_miso   = miso_reg;
    assign frame_done = frame_done_reg;
    assign last_addr  = last_addr_reg;
    assign frame_bits = frame_bits_reg;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: frame reads, pipelining, short/long frames, reset, collisions.
module tb_spi_adc_responder;

    localparam int HALF = 4;
`ifdef SPI_ADC_RESP_PROTO_CHECK_EN
    localparam logic PE_EXP = 1'b1;
`else
    localparam logic PE_EXP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [95:0] chan_data;
    logic        frame_done;
    logic [2:0]  last_addr;
    logic [4:0]  frame_bits;
    logic        proto_err;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    spi_adc_responder #(.SYNC_STAGES(2), .DATA_BITS(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .chan_data (chan_data),
        .frame_done(frame_done),
        .last_addr (last_addr),
        .frame_bits(frame_bits),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One master frame; MISO sampled just before each SCK rise, MOSI set half a period earlier.
    task automatic do_frame(input int nr, input logic [2:0] addr, input int chg_at,
                            input int rst_at, input bit collide, output logic [31:0] word);
        word     = '0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b0;
        for (int k = 1; k <= nr; k++) begin
            spi_mosi = (k >= 3 && k <= 5) ? addr[5-k] : 1'b0;
            wait_clk(HALF);
            word    = {word[30:0], spi_miso};
            spi_sck = 1'b1;
            if (k == chg_at) chan_data[12 +: 12] = 12'hFFF;
            if (k == rst_at) begin
                rst = 1'b0;
                wait_clk(1);
                check("rst_miso", {31'd0, spi_miso}, 32'd0);
                check("rst_last_addr", {29'd0, last_addr}, 32'd0);
                check("rst_frame_bits", {27'd0, frame_bits}, 32'd0);
                check("rst_proto_err", {31'd0, proto_err}, 32'd0);
                spi_cs_n = 1'b1;
                spi_sck  = 1'b0;
                wait_clk(4);
                rst = 1'b1;
                wait_clk(6);
                return;
            end
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
        wait_clk(HALF);
        if (collide) spi_sck = 1'b1;
        spi_cs_n = 1'b1;
        wait_clk(8);
        spi_sck = 1'b0;
        wait_clk(6);
    endtask

    logic [31:0] word;
    int          done_before;

    initial begin
        rst       = 1'b0;
        spi_sck   = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        chan_data = '0;
        chan_data[0  +: 12] = 12'hABC;
        chan_data[12 +: 12] = 12'h123;
        chan_data[24 +: 12] = 12'h222;
        chan_data[36 +: 12] = 12'h333;
        chan_data[48 +: 12] = 12'h444;
        chan_data[60 +: 12] = 12'h555;
        chan_data[72 +: 12] = 12'h666;
        chan_data[84 +: 12] = 12'h777;
        wait_clk(5);
        check("reset_miso", {31'd0, spi_miso}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_last_addr", {29'd0, last_addr}, 32'd0);
        check("reset_frame_bits", {27'd0, frame_bits}, 32'd0);
        check("reset_proto_err", {31'd0, proto_err}, 32'd0);
        rst = 1'b1;
        wait_clk(6);

        // Power-up read returns CH0 while sending address 1.
        done_before = done_cnt;
        do_frame(16, 3'd1, 0, 0, 1'b0, word);
        $display("frame1 addr=1 miso=0x%04h bits=%0d last=%0d", word[15:0], frame_bits, last_addr);
        check("f1_word", word, 32'h0ABC);
        check("f1_last_addr", {29'd0, last_addr}, 32'd1);
        check("f1_frame_bits", {27'd0, frame_bits}, 32'd16);
        check("f1_done_pulses", done_cnt - done_before, 32'd1);
        check("f1_proto_err", {31'd0, proto_err}, 32'd0);

        done_before = done_cnt;
        do_frame(16, 3'd0, 0, 0, 1'b0, word);
        $display("frame2 addr=0 miso=0x%04h bits=%0d last=%0d", word[15:0], frame_bits, last_addr);
        check("f2_word", word, 32'h0123);
        check("f2_last_addr", {29'd0, last_addr}, 32'd0);
        check("f2_done_pulses", done_cnt - done_before, 32'd1);

        do_frame(16, 3'd2, 0, 0, 1'b0, word);
        $display("frame3 addr=2 miso=0x%04h bits=%0d last=%0d", word[15:0], frame_bits, last_addr);
        check("f3_word", word, 32'h0ABC);
        check("f3_last_addr", {29'd0, last_addr}, 32'd2);

        // Controller-style 17-rise frame: 17th bit must be zero.
        do_frame(17, 3'd3, 0, 0, 1'b0, word);
        $display("frame4 addr=3 long miso=0x%05h bits=%0d last=%0d", word[16:0], frame_bits, last_addr);
        check("f4_word17", {15'd0, word[16:0]}, 32'h0444);
        check("f4_frame_bits", {27'd0, frame_bits}, 32'd17);
        check("f4_last_addr", {29'd0, last_addr}, 32'd3);
        check("f4_proto_err", {31'd0, proto_err}, 32'd0);

        // Short frame: address 7 must not take effect.
        done_before = done_cnt;
        do_frame(3, 3'd7, 0, 0, 1'b0, word);
        $display("frame5 addr=7 short bits=%0d last=%0d perr=%0d", frame_bits, last_addr, proto_err);
        check("f5_frame_bits", {27'd0, frame_bits}, 32'd3);
        check("f5_last_addr", {29'd0, last_addr}, 32'd3);
        check("f5_proto_err", {31'd0, proto_err}, {31'd0, PE_EXP});
        check("f5_done_pulses", done_cnt - done_before, 32'd1);

        do_frame(16, 3'd1, 0, 0, 1'b0, word);
        $display("frame6 addr=1 miso=0x%04h bits=%0d last=%0d", word[15:0], frame_bits, last_addr);
        check("f6_word", word, 32'h0333);
        check("f6_last_addr", {29'd0, last_addr}, 32'd1);
        check("f6_proto_err", {31'd0, proto_err}, {31'd0, PE_EXP});

        // CH1 changes mid-frame; frame in flight keeps its snapshot.
        do_frame(16, 3'd5, 8, 0, 1'b0, word);
        $display("frame7 addr=5 midchange miso=0x%04h last=%0d", word[15:0], last_addr);
        check("f7_word", word, 32'h0123);
        check("f7_last_addr", {29'd0, last_addr}, 32'd5);

        // Reset asserted at bit 10 of a CH5 read (MISO is 1 at that point).
        do_frame(16, 3'd1, 0, 10, 1'b0, word);
        $display("frame8 addr=1 reset at rise 10 last=%0d bits=%0d", last_addr, frame_bits);

        // First frame after reset returns CH0; its last SCK rise collides with CS_n rise.
        done_before = done_cnt;
        do_frame(16, 3'd6, 0, 0, 1'b1, word);
        $display("frame9 addr=6 collide miso=0x%04h bits=%0d last=%0d", word[15:0], frame_bits, last_addr);
        check("f9_word", word, 32'h0ABC);
        check("f9_frame_bits", {27'd0, frame_bits}, 32'd16);
        check("f9_done_pulses", done_cnt - done_before, 32'd1);
        check("f9_last_addr", {29'd0, last_addr}, 32'd6);

        do_frame(16, 3'd0, 0, 0, 1'b0, word);
        $display("frame10 addr=0 miso=0x%04h bits=%0d last=%0d", word[15:0], frame_bits, last_addr);
        check("f10_word", word, 32'h0666);
        check("f10_last_addr", {29'd0, last_addr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
